mul_div_seq: RTL

MUL_DIV_SEQ -- requirements
Module: mul_div_seq

---
 rtl/mul_div_seq_pkg.sv | 24 ++
 rtl/mul_div_seq_rca.sv | 24 ++
 rtl/mul_div_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mul_div_seq_pkg.sv
// rtl/mul_div_seq_pkg.sv - shared op/state encodings and widths for mul_div_seq
package mul_div_seq_pkg;

  localparam int XLEN    = 32;
  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    MD_MUL   = 2'b00,
    MD_MULHU = 2'b01,
    MD_DIVU  = 2'b10,
    MD_REMU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIN  = 2'b10
  } md_state_t;

  function automatic logic md_is_div(md_op_t o);
    return (o == MD_DIVU) || (o == MD_REMU);
  endfunction

endpackage

// File: rtl/mul_div_seq_rca.sv
// rtl/mul_div_seq_rca.sv - ripple-carry adder (x + y + cin) with carry-out
module mul_div_seq_rca #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic carry;

  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = x[i] ^ y[i] ^ carry;
      carry  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/mul_div_seq.sv
// rtl/mul_div_seq.sv - sequential unsigned MUL/MULHU/DIVU/REMU, one bit per cycle
// Divide path present only when MD_DIV_EN is defined.
module mul_div_seq
  import mul_div_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  md_state_t       state;
  md_op_t          op_q;
  logic [5:0]      count;
  // hi: product high half / partial remainder; lo: multiplier / dividend-then-quotient
  logic [XLEN-1:0] hi, lo, opnd;

  logic [XLEN-1:0] add_x, add_y, sum;
  logic            add_cin, cout;

  mul_div_seq_rca #(.W(XLEN)) u_rca (
    .x    (add_x),
    .y    (add_y),
    .cin  (add_cin),
    .sum  (sum),
    .cout (cout)
  );

`ifdef MD_DIV_EN
  logic quo_bit;
  // A set rem[31] means the shifted remainder exceeds 32 bits, so it is always >= divisor
  assign quo_bit = cout | hi[XLEN-1];
`endif

  always_comb begin
    add_x   = hi;
    add_y   = lo[0] ? opnd : '0;
    add_cin = 1'b0;
`ifdef MD_DIV_EN
    if (md_is_div(op_q)) begin
      add_x   = {hi[XLEN-2:0], lo[XLEN-1]};
      add_y   = ~opnd;
      add_cin = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      op_q   <= MD_MUL;
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= md_op_t'(op);
            count <= '0;
            hi    <= '0;
            busy  <= 1'b1;
`ifdef MD_DIV_EN
            if (md_is_div(md_op_t'(op))) begin
              opnd <= b;
              lo   <= a;
            end else begin
              opnd <= a;
              lo   <= b;
            end
            state <= S_CALC;
`else
            opnd  <= a;
            lo    <= b;
            state <= md_is_div(md_op_t'(op)) ? S_FIN : S_CALC;
`endif
          end
        end
        S_CALC: begin
`ifdef MD_DIV_EN
          if (md_is_div(op_q)) begin
            hi <= quo_bit ? sum : add_x;
            lo <= {lo[XLEN-2:0], quo_bit};
          end else begin
            hi <= {cout, sum[XLEN-1:1]};
            lo <= {sum[0], lo[XLEN-1:1]};
          end
`else
          hi <= {cout, sum[XLEN-1:1]};
          lo <= {sum[0], lo[XLEN-1:1]};
`endif
          count <= count + 6'd1;
          if (count == 6'(MD_ITER - 1)) state <= S_FIN;
        end
        S_FIN: begin
          unique case (op_q)
            MD_MUL:   result <= lo;
            MD_MULHU: result <= hi;
`ifdef MD_DIV_EN
            MD_DIVU:  result <= lo;
            MD_REMU:  result <= hi;
`else
            default:  result <= '0;
`endif
          endcase
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
